// File: rtl/ring_monitor.sv
// Lock/fault monitor for an upstream 8-bit rotate-left one-hot ring counter.
// Tracks hot-bit position, acquires lock, flags faults and counts revolutions.
module ring_monitor #(
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned REV_W    = 8
) (
    input  logic             clk,
    input  logic             init,
    input  logic [7:0]       ring,
    input  logic             clr_err,
    output logic [2:0]       idx,
    output logic             locked,
    output logic             err,
    output logic [3:0]       err_cnt,
    output logic [REV_W-1:0] rev_cnt,
    output logic             rev_tick
);

    typedef enum logic [1:0] {SYNC, ACQ, LOCKED, FAULT} state_t;

    localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);

    state_t     state;
    logic [7:0] prev;
    logic [2:0] good_cnt;
    logic       onehot;
    logic       good;
    logic       rev_step;
    logic [2:0] hot_pos;

    always_comb begin
        onehot   = $onehot(ring);
        good     = onehot && (ring == {prev[6:0], prev[7]});
        rev_step = good && (prev == 8'h80) && (ring == 8'h01);
        hot_pos  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (ring[i]) hot_pos = i[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state    <= SYNC;
            prev     <= '0;
            good_cnt <= '0;
            idx      <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            rev_cnt  <= '0;
            rev_tick <= 1'b0;
        end else begin
            prev     <= ring;
            rev_tick <= 1'b0;
            if (onehot) idx <= hot_pos;
            // Fault detection in LOCKED is assigned later so it overrides this clear.
            if (clr_err) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end
            case (state)
                SYNC: begin
                    if (onehot) begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                end
                ACQ: begin
                    if (good) begin
                        good_cnt <= good_cnt + 3'd1;
                        if ((good_cnt + 3'd1) == LOCK_TGT) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else begin
                        state <= SYNC;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        if (rev_step) begin
                            rev_cnt  <= rev_cnt + REV_W'(1);
                            rev_tick <= 1'b1;
                        end
                    end else begin
                        state   <= FAULT;
                        locked  <= 1'b0;
                        err     <= 1'b1;
                        if (clr_err)              err_cnt <= 4'd1;
                        else if (err_cnt != 4'hf) err_cnt <= err_cnt + 4'd1;
                    end
                end
                FAULT: begin
                    state <= SYNC;
                end
                default: begin
                    state  <= SYNC;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor: behavioural model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_ring_monitor;

    localparam int unsigned LOCK_CNT = 2;
    localparam int unsigned REV_W    = 8;

    logic             clk = 1'b0;
    logic             init = 1'b1;
    logic             clr_err = 1'b0;
    logic [7:0]       ring = 8'h00;
    logic [2:0]       idx;
    logic             locked;
    logic             err;
    logic [3:0]       err_cnt;
    logic [REV_W-1:0] rev_cnt;
    logic             rev_tick;

    ring_monitor #(.LOCK_CNT(LOCK_CNT), .REV_W(REV_W)) dut (
        .clk(clk), .init(init), .ring(ring), .clr_err(clr_err),
        .idx(idx), .locked(locked), .err(err), .err_cnt(err_cnt),
        .rev_cnt(rev_cnt), .rev_tick(rev_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ticks_seen = 0;
    bit check_en = 1'b0;
    logic [7:0] cur;

    // Model: whether we are hunting for a candidate, how many good steps in a
    // row since the candidate, whether lock is held, and whether the one-cycle
    // fault penalty is pending.
    logic [7:0]       m_prev;
    logic [2:0]       m_idx;
    logic             m_err, m_tick;
    int               m_cnt, m_streak;
    logic [REV_W-1:0] m_rev;
    bit               m_acq, m_lock, m_penalty;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rot(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    task automatic model_update(input logic [7:0] r, input logic clr, input logic rst);
        bit oh, good, fault;
        if (rst) begin
            m_prev = 8'h00; m_idx = 3'd0; m_err = 1'b0; m_tick = 1'b0;
            m_cnt = 0; m_streak = 0; m_rev = '0;
            m_acq = 0; m_lock = 0; m_penalty = 0;
            return;
        end
        oh    = ($countones(r) == 1);
        good  = oh && (r == rot(m_prev));
        fault = 0;
        m_tick = 1'b0;
        if (m_penalty) begin
            m_penalty = 0;
        end else if (m_lock) begin
            if (!good) begin
                m_lock = 0; m_penalty = 1; fault = 1;
            end else if (m_prev == 8'h80 && r == 8'h01) begin
                m_rev = m_rev + 1'b1; m_tick = 1'b1;
            end
        end else if (m_acq) begin
            if (good) begin
                m_streak++;
                if (m_streak == LOCK_CNT) begin
                    m_lock = 1; m_acq = 0;
                end
            end else begin
                m_acq = 0;
            end
        end else if (oh) begin
            m_acq = 1; m_streak = 0;
        end
        if (fault) begin
            m_err = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt + 1 > 15) ? 15 : m_cnt + 1);
        end else if (clr) begin
            m_err = 1'b0; m_cnt = 0;
        end
        if (oh) m_idx = 3'($clog2(r));
        m_prev = r;
    endtask

    task automatic step(input logic [7:0] r, input logic clr, input logic rst);
        ring = r; clr_err = clr; init = rst;
        @(posedge clk);
        model_update(r, clr, rst);
        #1;
        check_en = 1'b1;
    endtask

    task automatic relock();
        step(8'h01, 1'b0, 1'b0);
        step(8'h02, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        cur = 8'h04;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("idx", 32'(idx), 32'(m_idx));
            chk("locked", 32'(locked), 32'(m_lock));
            chk("err", 32'(err), 32'(m_err));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            chk("rev_cnt", 32'(rev_cnt), 32'(m_rev));
            chk("rev_tick", 32'(rev_tick), 32'(m_tick));
            if (rev_tick === 1'b1) ticks_seen++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        chk("rst_idx", 32'(idx), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_rev_cnt", 32'(rev_cnt), 0);

        // Acquisition from 0x80
        step(8'h80, 1'b0, 1'b0);
        chk("acq_idx7", 32'(idx), 7);
        step(8'h01, 1'b0, 1'b0);
        chk("acq_not_locked", 32'(locked), 0);
        step(8'h02, 1'b0, 1'b0);
        chk("acq_locked", 32'(locked), 1);
        chk("acq_idx1", 32'(idx), 1);
        cur = 8'h02;

        // Free rotation: 16 steps, two revolutions
        ticks_seen = 0;
        for (int i = 0; i < 16; i++) begin
            cur = rot(cur);
            step(cur, 1'b0, 1'b0);
        end
        @(negedge clk); #1;
        chk("rot_ticks", 32'(ticks_seen), 2);
        chk("rot_rev_cnt", 32'(rev_cnt), 2);

        // Multi-bit injection while locked
        step(8'h06, 1'b0, 1'b0);
        chk("flt_locked", 32'(locked), 0);
        chk("flt_err", 32'(err), 1);
        chk("flt_err_cnt", 32'(err_cnt), 1);
        chk("flt_idx_hold", 32'(idx), 1);
        step(8'h04, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b0);
        step(8'h10, 1'b0, 1'b0);
        step(8'h20, 1'b0, 1'b0);
        chk("reacq_locked", 32'(locked), 1);

        // 16 more faults -> saturation
        for (int i = 0; i < 16; i++) begin
            step(8'h06, 1'b0, 1'b0);
            step(8'h00, 1'b0, 1'b0);
            relock();
        end
        chk("sat_err_cnt", 32'(err_cnt), 15);
        step(8'h08, 1'b1, 1'b0);
        chk("clr_err", 32'(err), 0);
        chk("clr_err_cnt", 32'(err_cnt), 0);

        // clr_err coinciding with a fault
        step(8'h03, 1'b1, 1'b0);
        chk("clrflt_err", 32'(err), 1);
        chk("clrflt_err_cnt", 32'(err_cnt), 1);

        // Frozen ring while locked
        step(8'h00, 1'b0, 1'b0);
        relock();
        step(8'h04, 1'b0, 1'b0);
        chk("frozen_err_cnt", 32'(err_cnt), 2);
        chk("frozen_locked", 32'(locked), 0);

        // Three more revolutions, then init mid-lock
        step(8'h00, 1'b0, 1'b0);
        relock();
        for (int i = 0; i < 24; i++) begin
            cur = rot(cur);
            step(cur, 1'b0, 1'b0);
        end
        chk("rev5", 32'(rev_cnt), 5);
        step(rot(cur), 1'b1, 1'b1);
        chk("init_locked", 32'(locked), 0);
        chk("init_rev_cnt", 32'(rev_cnt), 0);
        chk("init_err_cnt", 32'(err_cnt), 0);
        chk("init_idx", 32'(idx), 0);
        for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0);
        chk("idle_locked", 32'(locked), 0);
        chk("idle_err", 32'(err), 0);

        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_monitor.md
RING_MONITOR -- requirements
Module: ring_monitor

Interface
REQ-001 Parameter LOCK_CNT, default 2: consecutive correct rotation steps needed to declare lock; legal range 1..7.
REQ-002 Parameter REV_W, default 8: width of the revolution counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port init, input, 1: reset, synchronous and active-high.
REQ-005 Port ring, input, 8: pattern from the upstream 8-bit rotate-left ring counter; expected step is next = {ring[6:0], ring[7]}.
REQ-006 Port clr_err, input, 1: synchronous clear of err and err_cnt.
REQ-007 Port idx, output, 3: registered binary position of the hot bit in the last sampled one-hot ring.
REQ-008 Port locked, output, 1: high while the FSM is in LOCKED.
REQ-009 Port err, output, 1: sticky fault flag.
REQ-010 Port err_cnt, output, 4: fault count, saturating at 15.
REQ-011 Port rev_cnt, output, REV_W: completed revolutions counted while locked; wraps modulo 2^REV_W.
REQ-012 Port rev_tick, output, 1: one-cycle pulse per counted revolution.

Function
REQ-013 The block shall sample ring every clk cycle into register prev; all outputs are registered, with 1-cycle latency from a ring sample.
REQ-014 The sample is "onehot" iff exactly one bit of ring is set; 0x00 and multi-bit values are not onehot.
REQ-015 A step is "good" iff the sample is onehot and ring == {prev[6:0], prev[7]}.
REQ-016 idx shall update only on onehot samples and hold its value otherwise.
REQ-017 FSM states: SYNC, ACQ, LOCKED, FAULT; reset state is SYNC.
REQ-018 SYNC: onehot sample -> ACQ with good_cnt=0; otherwise stay in SYNC.
REQ-019 ACQ: good step -> good_cnt+1, and when the incremented value equals LOCK_CNT -> LOCKED; non-good sample -> SYNC with no error raised.
REQ-020 LOCKED: good step -> stay; non-good sample -> FAULT, set err, increment err_cnt (saturating at 15).
REQ-021 FAULT shall last exactly one cycle, then go to SYNC; locked is low in FAULT.
REQ-022 A revolution is counted only in LOCKED, on a good step with prev==0x80 and ring==0x01: rev_cnt+1 and rev_tick=1 in the next cycle.
REQ-023 rev_tick shall be low in all other cycles; rev_cnt holds across loss of lock.
REQ-024 clr_err shall clear err and err_cnt to 0 on the next edge.
REQ-025 If clr_err coincides with a new fault detection, the fault shall win: err=1, err_cnt=1.
REQ-026 A ring value frozen while locked (e.g., upstream init held) is not a good step and shall produce a FAULT.

Reset
REQ-027 While init=1 at a clk edge: state=SYNC, prev=0x00, good_cnt=0, idx=0, locked=0, err=0, err_cnt=0, rev_cnt=0, rev_tick=0.
REQ-028 init shall take priority over clr_err and over all FSM activity, including mid-lock and mid-fault.
REQ-029 The first cycle after init deasserts shall be evaluated from SYNC, with prev=0x00.

Verification
REQ-030 Release init with ring sequence 0x80,0x01,0x02 -> ACQ after 0x80; locked=1 the cycle after 0x02 is sampled (LOCK_CNT=2); idx=1 then 2.
REQ-031 Locked, with ring rotating freely for 16 steps -> rev_tick pulses exactly twice, one cycle after each 0x80->0x01 step; rev_cnt=2.
REQ-032 Locked, with ring injected as 0x06 -> FAULT for one cycle, err=1, err_cnt=1, locked=0, idx holds; SYNC re-acquires on the next onehot sample.
REQ-033 Drive 17 faults -> err_cnt saturates at 15; clr_err pulse on a non-fault cycle -> err=0, err_cnt=0.
REQ-034 clr_err asserted on the same edge as a fault -> err=1, err_cnt=1.
REQ-035 Assert init while locked with rev_cnt=5 -> all outputs at their reset values on the next edge; ring 0x00 held afterwards -> stays in SYNC with err=0.
